// File: rtl/ifetch_req.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_req
// Purpose  : PC generation and instruction-bus request stage. Owns the fetch
//            PC, issues hold-until-data_ok bus requests and presents a
//            registered {pc, raw_instr, misalign} slot to the fetch stage.
//            A one-entry skid buffer absorbs a bus response that arrives while
//            the slot is stalled.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            ireq_valid/ireq_addr  - instruction-bus request
//            iresp_data_ok/_data   - instruction-bus response
//            stall                 - downstream cannot take the slot
//            redirect_valid/_pc    - flush and restart fetch
//            out_valid/out_pc/out_raw_instr/out_misalign - output slot
//            perf_fetched/perf_stall_cycles - only with IFETCH_PERF_CNT_EN
// Options  : IFETCH_PERF_CNT_EN adds the two performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_req #(
    parameter logic [63:0] PC_INIT = 64'h0000_0000_8000_0000,
    parameter int unsigned PC_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_raw_instr,
    output logic        out_misalign
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetched,
    output logic [63:0] perf_stall_cycles
`endif
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] drain_addr_q, drain_addr_d;
    logic [63:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [31:0] out_raw_q, out_raw_d;
    logic        out_misalign_q, out_misalign_d;
    logic        slot_free;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_REQ;
            pc_q           <= PC_INIT;
            drain_addr_q   <= '0;
            skid_pc_q      <= '0;
            skid_data_q    <= '0;
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_raw_q      <= '0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            drain_addr_q   <= drain_addr_d;
            skid_pc_q      <= skid_pc_d;
            skid_data_q    <= skid_data_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_raw_q      <= out_raw_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and slot/skid update
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drain_addr_d   = drain_addr_q;
        skid_pc_d      = skid_pc_q;
        skid_data_d    = skid_data_q;
        // A stalled valid slot keeps its contents; a consumed one empties
        // unless something below refills it.
        out_valid_d    = out_valid_q & stall;
        out_pc_d       = out_pc_q;
        out_raw_d      = out_raw_q;
        out_misalign_d = out_misalign_q;
        slot_free      = !out_valid_q || !stall;

        if (redirect_valid) begin
            out_valid_d = 1'b0;
            skid_pc_d   = '0;
            skid_data_d = '0;
            pc_d        = redirect_pc;
            if (ireq_valid && !iresp_data_ok) begin
                // The bus still owes a response; keep presenting the address
                // it was issued with (already latched if we are draining).
                state_d      = S_DRAIN;
                drain_addr_d = ireq_addr;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (pc_q[1:0] != 2'b00) begin
                        if (slot_free) begin
                            out_valid_d    = 1'b1;
                            out_pc_d       = pc_q;
                            out_raw_d      = '0;
                            out_misalign_d = 1'b1;
                            state_d        = S_HALT;
                        end
                    end else if (iresp_data_ok) begin
                        pc_d = pc_q + 64'(PC_STEP);
                        if (slot_free) begin
                            out_valid_d    = 1'b1;
                            out_pc_d       = pc_q;
                            out_raw_d      = iresp_data;
                            out_misalign_d = 1'b0;
                        end else begin
                            skid_pc_d   = pc_q;
                            skid_data_d = iresp_data;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        out_valid_d    = 1'b1;
                        out_pc_d       = skid_pc_q;
                        out_raw_d      = skid_data_q;
                        out_misalign_d = 1'b0;
                        state_d        = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (iresp_data_ok) begin
                        state_d = S_REQ;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus request outputs
    // ------------------------------------------------------------------
    always_comb begin
        ireq_valid = 1'b0;
        ireq_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
        if (!reset) begin
            case (state_q)
                S_REQ:   ireq_valid = (pc_q[1:0] == 2'b00);
                S_DRAIN: ireq_valid = 1'b1;
                default: ireq_valid = 1'b0;
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign out_raw_instr = out_raw_q;
    assign out_misalign  = out_misalign_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [63:0] perf_fetched_q, perf_fetched_d;
    logic [63:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q
                       + {63'd0, out_valid_q & ~stall & ~out_misalign_q};
        perf_stall_d   = perf_stall_q + {63'd0, out_valid_q & stall};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_req
// Purpose  : Randomized self-checking bench for ifetch_req. A driver issues
//            bus responses, stalls, redirects and resets; it predicts the
//            stream of instructions the fetch stage should receive and pushes
//            them into a queue. A monitor pops and compares on every consumed
//            slot. Bus-protocol, latency and hold rules are checked alongside.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_req;

    localparam logic [63:0] PC_INIT = 64'h0000_0000_8000_0000;
    localparam int          N_CYC   = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_raw_instr;
    logic        out_misalign;
`ifdef IFETCH_PERF_CNT_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_stall_cycles;
`endif

    ifetch_req #(.PC_INIT(PC_INIT), .PC_STEP(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_raw_instr  (out_raw_instr),
        .out_misalign   (out_misalign)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } item_t;

    item_t exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;

    // Reference model state (instruction-stream level)
    logic [63:0] model_pc = PC_INIT;
    bit          drain_pending = 0;
    bit          halted = 0;
    bit          flush_pending = 0;
    bit          lat_now = 0;
    logic [63:0] lat_now_pc = '0;
    longint      model_fetched = 0;
    longint      model_stalls = 0;

    // Driver's view of the previous cycle's bus
    bit          drv_prev_iv = 0;
    bit          drv_prev_dok = 0;
    bit          drv_prev_rst = 1;
    logic [63:0] drv_prev_addr = '0;

    // Monitor's view of the previous cycle's slot
    bit          mon_prev_rst = 1;
    bit          mon_prev_redir = 0;
    bit          mon_prev_valid = 0;
    bit          mon_prev_stall = 0;
    logic [63:0] mon_prev_pc = '0;
    logic [31:0] mon_prev_raw = '0;
    bit          mon_prev_mis = 0;
    bit          lat_prev = 0;
    logic [63:0] lat_prev_pc = '0;

    // Memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pick_redirect();
        logic [63:0] a;
        case ($urandom_range(0, 5))
            0:       a = 64'h0000_0000_8000_0100;
            1:       a = 64'h0000_0000_8000_0102;
            2:       a = 64'h0000_0000_8000_0200;
            3:       a = PC_INIT + (64'($urandom_range(0, 1023)) << 2);
            4:       a = 64'hFFFF_FFFF_FFFF_FFF8;
            default: a = PC_INIT + (64'($urandom_range(0, 255)) << 2) + 64'($urandom_range(1, 3));
        endcase
        return a;
    endfunction

    // Called at posedge+1 for the cycle about to be driven.
    task automatic step(input int mode);
        int    stall_pct;
        int    dok_pct;
        int    redir_pct;
        item_t it;
        case (mode)
            0:       begin stall_pct = 0;  dok_pct = 100; redir_pct = 0; end
            1:       begin stall_pct = 0;  dok_pct = 100; redir_pct = 2; end
            2:       begin stall_pct = 30; dok_pct = 50;  redir_pct = 4; end
            default: begin stall_pct = 70; dok_pct = 70;  redir_pct = 3; end
        endcase

        if (flush_pending) begin
            exp_q.delete();
            flush_pending = 0;
        end
        // Once any stale response is drained, a misaligned PC yields one marker.
        if (!halted && !drain_pending && model_pc[1:0] != 2'b00) begin
            it.pc = model_pc; it.instr = '0; it.mis = 1'b1;
            exp_q.push_back(it);
            halted = 1;
        end

        check_eq("pending_depth_le2", 64'(exp_q.size() <= 2), 1);
        if (exp_q.size() == 2 || halted)
            check_eq("no_request_while_full_or_halted", ireq_valid, 0);
        if (drv_prev_iv && !drv_prev_dok && !drv_prev_rst) begin
            check_eq("request_held_valid", ireq_valid, 1);
            check_eq("request_held_addr", ireq_addr, drv_prev_addr);
        end
        if (ireq_valid && !drain_pending)
            check_eq("request_addr", ireq_addr, model_pc);

        stall          = ($urandom_range(0, 99) < stall_pct);
        redirect_valid = ($urandom_range(0, 99) < (halted ? 30 : redir_pct));
        redirect_pc    = redirect_valid ? pick_redirect() : 64'($urandom);
        iresp_data_ok  = ireq_valid && ($urandom_range(0, 99) < dok_pct);
        iresp_data     = iresp_data_ok ? mem_word(ireq_addr) : $urandom;

        lat_now = 0;
        if (redirect_valid) begin
            drain_pending = ireq_valid && !iresp_data_ok;
            model_pc      = redirect_pc;
            flush_pending = 1;
            halted        = 0;
        end else if (iresp_data_ok) begin
            if (drain_pending) begin
                drain_pending = 0;
            end else begin
                it.pc = model_pc; it.instr = mem_word(model_pc); it.mis = 1'b0;
                exp_q.push_back(it);
                lat_now    = !out_valid || !stall;
                lat_now_pc = model_pc;
                model_pc   = model_pc + 64'd4;
            end
        end

        drv_prev_iv   = ireq_valid;
        drv_prev_dok  = iresp_data_ok;
        drv_prev_addr = ireq_addr;
        drv_prev_rst  = 0;
    endtask

    task automatic do_reset(input int n);
        reset          = 1'b1;
        iresp_data_ok  = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        exp_q.delete();
        model_pc      = PC_INIT;
        drain_pending = 0;
        halted        = 0;
        flush_pending = 0;
        lat_now       = 0;
        model_fetched = 0;
        model_stalls  = 0;
        repeat (n) @(posedge clk);
        #1;
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_out_pc", out_pc, 0);
        check_eq("reset_out_raw_instr", out_raw_instr, 0);
        check_eq("reset_out_misalign", out_misalign, 0);
        check_eq("reset_ireq_valid", ireq_valid, 0);
`ifdef IFETCH_PERF_CNT_EN
        check_eq("reset_perf_fetched", perf_fetched, 0);
        check_eq("reset_perf_stall", perf_stall_cycles, 0);
`endif
        reset        = 1'b0;
        drv_prev_rst = 1;
    endtask

    // Monitor: checks slot behaviour and scoreboards every consumed slot.
    always @(negedge clk) begin
        item_t it;
        if (!reset) begin
            if (!mon_prev_rst) begin
                if (mon_prev_redir) begin
                    check_eq("valid_clear_after_redirect", out_valid, 0);
                end else if (mon_prev_valid && mon_prev_stall) begin
                    check_eq("stall_hold_valid", out_valid, 1);
                    check_eq("stall_hold_pc", out_pc, mon_prev_pc);
                    check_eq("stall_hold_raw", out_raw_instr, mon_prev_raw);
                    check_eq("stall_hold_misalign", out_misalign, mon_prev_mis);
                end
                if (lat_prev) begin
                    check_eq("latency_valid", out_valid, 1);
                    check_eq("latency_pc", out_pc, lat_prev_pc);
                end
            end
            if (out_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc 0x%0h expected no instruction at %0t", out_pc, $time);
                end else begin
                    it = exp_q.pop_front();
                    check_eq("out_pc", out_pc, it.pc);
                    check_eq("out_raw_instr", out_raw_instr, it.instr);
                    check_eq("out_misalign", out_misalign, it.mis);
                end
                if (!out_misalign) model_fetched++;
            end
            if (out_valid && stall) model_stalls++;
        end
        mon_prev_rst   = reset;
        mon_prev_redir = redirect_valid;
        mon_prev_valid = out_valid;
        mon_prev_stall = stall;
        mon_prev_pc    = out_pc;
        mon_prev_raw   = out_raw_instr;
        mon_prev_mis   = out_misalign;
        lat_prev       = lat_now && !reset;
        lat_prev_pc    = lat_now_pc;
    end

    initial begin
        int mode;
        do_reset(2);
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc == N_CYC / 2) do_reset(2);
            if (cyc < 30) mode = 0;
            else          mode = 1 + ((cyc / 150) % 3);
            step(mode);
            @(posedge clk);
            #1;
        end
`ifdef IFETCH_PERF_CNT_EN
        check_eq("perf_fetched", perf_fetched, 64'(model_fetched));
        check_eq("perf_stall_cycles", perf_stall_cycles, 64'(model_stalls));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
